// File: rtl/ps2_io_pkg.sv
// Shared constants, receiver state encoding and parity helper for the PS/2 FIFO port.
package ps2_io_pkg;

   // Register indices selected by adr_i[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   // STATUS register bit positions
   localparam int ST_NEMPTY = 0;
   localparam int ST_FULL   = 1;
   localparam int ST_OVF    = 2;
   localparam int ST_PERR   = 3;
   localparam int ST_FERR   = 4;

   // CTRL register bit positions (flush and clear are write-only strobes)
   localparam int CTRL_RX_EN  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_FLUSH  = 2;
   localparam int CTRL_CLR    = 3;

   // Value returned by a DATA read while the FIFO is empty
   localparam logic [7:0] EMPTY_CODE = 8'hAA;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   // Odd parity holds when data plus parity bit carry an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, frame FSM and inter-edge timeout.
module ps2_rx_frame
   import ps2_io_pkg::*;
#(
   parameter int FILT_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_en,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       valid,
   output logic       perr_pulse,
   output logic       ferr_pulse
);

   localparam int FW = $clog2(FILT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
   localparam logic [FW-1:0] FILT_ONE  = FW'(1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_ONE   = TW'(1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fall_edge;
   logic          sdata;
   rx_state_t     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_ok;
   logic [TW-1:0] tmo_cnt;

   // Two-flop synchronisers; lines idle high on the PS/2 bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Accept a new clock level only after FILT_CYCLES consecutive differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_sync[1] != filt_clk) begin
         if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FILT_ONE;
         end
      end else begin
         filt_cnt <= '0;
      end
   end

   assign fall_edge = filt_clk & ~clk_sync[1] & (filt_cnt == FILT_LAST);
   assign sdata     = data_sync[1];

   // Frame FSM with registered result pulses and inter-edge timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         par_ok     <= 1'b0;
         tmo_cnt    <= '0;
         rx_byte    <= 8'h00;
         valid      <= 1'b0;
         perr_pulse <= 1'b0;
         ferr_pulse <= 1'b0;
      end else begin
         valid      <= 1'b0;
         perr_pulse <= 1'b0;
         ferr_pulse <= 1'b0;
         if (!rx_en) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            tmo_cnt <= '0;
         end else if (fall_edge) begin
            tmo_cnt <= '0;
            case (state)
               IDLE: begin
                  bit_cnt <= 3'd0;
                  if (!sdata) state <= DATA;
                  else        state <= IDLE;
               end
               DATA: begin
                  shreg   <= {sdata, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
                  else                 state <= DATA;
               end
               PARITY: begin
                  par_ok <= odd_parity_ok(shreg, sdata);
                  state  <= STOP;
               end
               STOP: begin
                  if (!sdata) begin
                     ferr_pulse <= 1'b1;
                  end else if (!par_ok) begin
                     perr_pulse <= 1'b1;
                  end else begin
                     valid   <= 1'b1;
                     rx_byte <= shreg;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
               ferr_pulse <= 1'b1;
               state      <= IDLE;
               tmo_cnt    <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + TMO_ONE;
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_io_fifo.sv
// PS/2 keyboard port with receive FIFO, 4-register bus slave, level irq and scan-code history.
module ps2_io_fifo
   import ps2_io_pkg::*;
#(
   parameter int FIFO_DEPTH     = 16,
   parameter int HIST_BYTES     = 4,
   parameter int FILT_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                    io_read_clk,
   input  logic                    rst,
   input  logic [7:0]              dat_i,
   input  logic [31:0]             adr_i,
   input  logic                    we_i,
   input  logic                    stb_i,
   output logic [7:0]              dat_o,
   output logic                    ack_o,
   input  logic                    PS2_clk,
   input  logic                    PS2_Data,
   output logic                    ps2_ready,
   output logic                    irq,
   output logic                    overflow,
   output logic [8*HIST_BYTES-1:0] key_d
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int KW = 8 * HIST_BYTES;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   count_wide;
   logic          rx_en, irq_en, perr, ferr;
   logic [7:0]    rx_byte;
   logic          rx_valid, perr_pulse, ferr_pulse;
   logic          empty, full, rd_txn, wr_txn, ctrl_wr;
   logic          pop, push, flush, clr, ovf_event;
   logic [1:0]    reg_sel;
   logic [7:0]    status, count_rd, rd_data;
   logic          unused_bits;

   ps2_rx_frame #(
      .FILT_CYCLES    (FILT_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (io_read_clk),
      .rst        (rst),
      .rx_en      (rx_en),
      .ps2_clk    (PS2_clk),
      .ps2_data   (PS2_Data),
      .rx_byte    (rx_byte),
      .valid      (rx_valid),
      .perr_pulse (perr_pulse),
      .ferr_pulse (ferr_pulse)
   );

   assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i[7:4]};
   assign ack_o       = stb_i;
   assign reg_sel     = adr_i[3:2];
   assign rd_txn      = stb_i & ~we_i;
   assign wr_txn      = stb_i & we_i;
   assign ctrl_wr     = wr_txn & (reg_sel == REG_CTRL);
   assign empty       = (count == {CW{1'b0}});
   assign full        = (count == CNT_FULL);
   assign ps2_ready   = ~empty;
   assign pop         = rd_txn & (reg_sel == REG_DATA) & ~empty;
   assign flush       = ctrl_wr & dat_i[CTRL_FLUSH];
   assign clr         = ctrl_wr & dat_i[CTRL_CLR];
   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
   assign push        = rx_valid & (~full | pop) & ~flush;
   assign ovf_event   = rx_valid & full & ~pop & ~flush;
   assign count_wide  = 32'(count);

   // Assemble STATUS and saturated COUNT read values
   always_comb begin
      status              = 8'h00;
      status[ST_NEMPTY]   = ~empty;
      status[ST_FULL]     = full;
      status[ST_OVF]      = overflow;
      status[ST_PERR]     = perr;
      status[ST_FERR]     = ferr;
      if (count_wide > 32'd255) count_rd = 8'hFF;
      else                      count_rd = count_wide[7:0];
   end

   // Read data mux for the addressed register
   always_comb begin
      rd_data = EMPTY_CODE;
      case (reg_sel)
         REG_DATA: begin
            if (empty) rd_data = EMPTY_CODE;
            else       rd_data = mem[rd_ptr];
         end
         REG_STATUS: rd_data = status;
         REG_COUNT:  rd_data = count_rd;
         REG_CTRL:   rd_data = {6'b000000, irq_en, rx_en};
         default:    rd_data = EMPTY_CODE;
      endcase
   end

   // FIFO storage; contents are only meaningful between the pointers
   always_ff @(posedge io_read_clk) begin
      if (push) mem[wr_ptr] <= rx_byte;
   end

   // FIFO pointers and occupancy; flush takes priority over a same-cycle push
   always_ff @(posedge io_read_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Control register and sticky error flags; a new event beats a same-cycle clear
   always_ff @(posedge io_read_clk or posedge rst) begin
      if (rst) begin
         rx_en    <= 1'b1;
         irq_en   <= 1'b0;
         overflow <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            rx_en  <= dat_i[CTRL_RX_EN];
            irq_en <= dat_i[CTRL_IRQ_EN];
         end
         if (ovf_event)       overflow <= 1'b1;
         else if (clr)        overflow <= 1'b0;
         if (perr_pulse)      perr <= 1'b1;
         else if (clr)        perr <= 1'b0;
         if (ferr_pulse)      ferr <= 1'b1;
         else if (clr)        ferr <= 1'b0;
      end
   end

   // Registered bus read data, popped-byte history and interrupt level
   always_ff @(posedge io_read_clk or posedge rst) begin
      if (rst) begin
         dat_o <= 8'h00;
         key_d <= '0;
         irq   <= 1'b0;
      end else begin
         if (rd_txn) dat_o <= rd_data;
         if (pop)    key_d <= (key_d << 4'd8) | KW'(mem[rd_ptr]);
         irq <= irq_en & ~empty;
      end
   end

endmodule

// File: doc/ps2_io_fifo.md
Name: ps2_io_fifo

Overview:
- Parametrised successor to the single-byte PS/2 keyboard port.
- Receives PS/2 frames directly on io_read_clk, validates start, parity, stop and timeout, and buffers good bytes in a FIFO_DEPTH-entry FIFO.
- Exposes a 4-register bus slave (data, status, count, control) plus a level interrupt and a scan-code history.
- Sits on the CPU I/O bus in place of the legacy port; software drains bursts such as E0/F0 sequences without losing bytes.

Parameters:
- FIFO_DEPTH, 16: receive FIFO entries; power of 2, minimum 2.
- HIST_BYTES, 4: number of popped bytes kept in key_d.
- FILT_CYCLES, 4: io_read_clk cycles PS2_clk must be stable before an edge is accepted.
- TIMEOUT_CYCLES, 100000: maximum cycles between falling edges inside a frame.

Ports:
- io_read_clk  in   1  system/bus clock; all logic runs on it.
- rst  in  1  asynchronous, active-high reset.
- dat_i  in  8  bus write data.
- adr_i  in  32  bus address; adr_i[3:2] selects the register, other bits ignored.
- we_i  in  1  1 = write, 0 = read.
- stb_i  in  1  bus strobe.
- dat_o  out  8  registered read data.
- ack_o  out  1  equals stb_i (combinational, zero wait).
- PS2_clk  in  1  raw PS/2 clock, asynchronous.
- PS2_Data  in  1  raw PS/2 data, asynchronous.
- ps2_ready  out  1  FIFO non-empty.
- irq  out  1  registered; irq_en & ~empty.
- overflow  out  1  sticky FIFO-overflow flag.
- key_d  out  8*HIST_BYTES  history of popped bytes; newest byte in [7:0].

Behaviour:
- Reset values:
  - dat_o=0, key_d=0, irq=0, overflow=0, FIFO empty, all sticky errors 0.
  - rx_en=1, irq_en=0, receiver in IDLE.
- Input conditioning:
  - PS2_clk and PS2_Data each pass through a 2-FF synchroniser.
  - The filtered clock changes only after FILT_CYCLES consecutive equal samples.
  - A falling edge of the filtered clock samples synchronised data.
- Receiver FSM (sub-module):
  - IDLE -> DATA on edge with data=0 (start bit); edge with data=1 in IDLE is ignored.
  - DATA: 8 bits, LSB first, then -> PARITY.
  - PARITY: check odd parity over 9 bits, then -> STOP.
  - STOP: data=1 with good parity emits a 1-cycle valid pulse with the byte, then -> IDLE.
  - STOP with bad parity: set perr sticky, no push.
  - STOP with data=0: set ferr sticky, no push.
  - Timeout: in any non-IDLE state, TIMEOUT_CYCLES without an edge sets ferr, discards the frame, and returns to IDLE. The counter resets on every accepted edge.
  - rx_en=0 forces IDLE and discards any partial frame.
- FIFO:
  - Push on valid pulse. If full and no pop that cycle, drop the byte and set overflow.
  - Push and pop in the same cycle both take effect; when full this is accepted, not an overflow.
  - Pointers wrap modulo FIFO_DEPTH. Count has width clog2(FIFO_DEPTH)+1.
- Bus access: a transaction is stb_i=1 at a posedge.
  - dat_o updates only on read transactions and holds otherwise.
  - Read reg0 DATA: non-empty -> dat_o<=head, pop, key_d<={key_d shifted left 8, head}. Empty -> dat_o<=8'hAA, no pop, key_d unchanged.
  - Read reg1 STATUS: bit0 non-empty, bit1 full, bit2 overflow, bit3 perr, bit4 ferr, bits 7:5 = 0.
  - Read reg2 COUNT: FIFO count, saturated to 255.
  - Read reg3 CTRL: {6'b0, irq_en, rx_en}.
  - Write reg3: rx_en<=dat_i[0], irq_en<=dat_i[1].
    - dat_i[2]=1 flushes the FIFO; flush beats a same-cycle push, and the pushed byte is lost.
    - dat_i[3]=1 clears overflow, perr and ferr; a same-cycle new error event wins and the flag stays 1.
  - Writes to reg0..2 are ignored; ack_o is still returned.
- Outputs:
  - ps2_ready is combinational from FIFO state.
  - irq is registered and updates 1 cycle after a FIFO state change.
- Reset mid-frame or mid-access: immediate return to reset values; no partial push.

Decomposition:
- Package ps2_io_pkg holds:
  - register index constants: REG_DATA=0, REG_STATUS=1, REG_COUNT=2, REG_CTRL=3;
  - STATUS and CTRL bit positions;
  - EMPTY_CODE=8'hAA;
  - the receiver state enum {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_rx_frame contains the synchronisers, filter, FSM and timeout. Its outputs are byte[7:0], valid, perr_pulse and ferr_pulse.
- FIFO and register file stay in the top level.

Test Plan:
- Send frame 0x1C with correct parity, then read reg0 -> dat_o=0x1C, key_d[7:0]=0x1C, ps2_ready 1->0; a second reg0 read returns 0xAA.
- Send 0xE0, 0xF0, 0x74 back-to-back, then read reg2 -> 3; three reg0 reads -> E0, F0, 74 in order; key_d[23:0]=E0F074.
- Send FIFO_DEPTH+1 frames with no reads -> reg2=FIFO_DEPTH, overflow=1, STATUS=0x07; the first byte is retained; writing CTRL 0x09 clears overflow.
- Send frame with wrong parity -> no push, STATUS bit3=1. Drive 5 bits then idle for TIMEOUT_CYCLES -> STATUS bit4=1, FSM back in IDLE; the next good frame 0x29 is received correctly.
- Write CTRL 0x03 with an empty FIFO -> irq stays 0; receive 1 byte -> irq=1 one cycle after push; reg0 read -> irq=0.
- Assert rst mid-frame (after 4 data bits) -> all outputs 0 and rx_en=1; the next full frame 0x5A is received intact.
